// File: rtl/bus_dma_initiator.sv
// Word-copy DMA initiator for the simple memory bus: each word is one read,
// a capture cycle and one write, every access held until the responder's mem_done.
module bus_dma_initiator #(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [31:0]            src_addr_i,
    input  logic [31:0]            dst_addr_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   src_inc_i,
    input  logic                   dst_inc_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wmask,
    output logic                   mem_wstrb,
    output logic                   mem_rstrb,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_done
);
    // The wait counter only ever holds 0 .. TIMEOUT_CYCLES-1.
    localparam int WaitWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WaitWidth-1:0] WaitLimit = WaitWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [31:0]            data_q, data_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [WaitWidth-1:0]   wait_q, wait_d;
    logic                   src_inc_q, src_inc_d;
    logic                   dst_inc_q, dst_inc_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   wait_hit;

    assign wait_hit = (wait_q == WaitLimit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            data_q    <= '0;
            rem_q     <= '0;
            wait_q    <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        data_d    = data_q;
        rem_d     = rem_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        wait_d    = '0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    src_d     = src_addr_i & 32'hFFFF_FFFC;
                    dst_d     = dst_addr_i & 32'hFFFF_FFFC;
                    rem_d     = count_i;
                    src_inc_d = src_inc_i;
                    dst_inc_d = dst_inc_i;
                    if (count_i == '0) done_d = 1'b1;
                    else               state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (mem_done) begin
                    state_d = S_CAPTURE;
                end else if (wait_hit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitWidth'(1);
                end
            end
            S_CAPTURE: begin
                data_d  = mem_rdata;
                state_d = abort_i ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                // A write accepted together with abort still advances the pointers.
                if (mem_done) begin
                    if (src_inc_q) src_d = src_q + 32'd4;
                    if (dst_inc_q) dst_d = dst_q + 32'd4;
                    rem_d = rem_q - COUNT_WIDTH'(1);
                    if (abort_i) begin
                        state_d = S_IDLE;
                    end else if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end else if (abort_i) begin
                    state_d = S_IDLE;
                end else if (wait_hit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitWidth'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request decoded purely from registered state, so reset clears it at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        case (state_q)
            S_READ: begin
                mem_rstrb = 1'b1;
                mem_addr  = src_q;
            end
            S_WRITE: begin
                mem_wstrb = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = data_q;
                mem_wmask = 4'hF;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule
